// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the 3-digit multiplexed 7-segment scanner.
//   DIG_U / DIG_D / DIG_C : one-hot digit selects (units / tens / hundreds)
//   N_DIGITS              : number of multiplexed digits
//   digit_sel_t           : one-hot digit select type
//   bcd3_t                : packed 3-digit BCD value ([3:0] units .. [11:8] hundreds)
//   next_sel()            : scan rotation, recovering any non-one-hot value to DIG_U
// ---------------------------------------------------------------------------
package display_pkg;

  localparam int N_DIGITS = 3;

  typedef logic [2:0]  digit_sel_t;
  typedef logic [11:0] bcd3_t;

  localparam digit_sel_t DIG_U = 3'b001;
  localparam digit_sel_t DIG_D = 3'b010;
  localparam digit_sel_t DIG_C = 3'b100;

  // Next digit in the scan order; anything that is not a legal one-hot
  // select (e.g. after a register upset) restarts the frame at the units.
  function automatic digit_sel_t next_sel(input digit_sel_t cur);
    digit_sel_t nxt;
    case (cur)
      DIG_U:   nxt = DIG_D;
      DIG_D:   nxt = DIG_C;
      DIG_C:   nxt = DIG_U;
      default: nxt = DIG_U;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Slot prescaler: counts 0..DIV-1 while enabled, holds while disabled.
// Ports:
//   i_clk   in   system clock
//   i_rst   in   synchronous active-high reset (cnt -> 0)
//   i_en    in   count enable; 0 freezes the count
//   o_cnt   out  current count within the slot
//   o_wrap  out  high on the enabled cycle where cnt==DIV-1 (slot ends at
//                the next edge); derived from the count register and i_en
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int DIV = 27000,
  parameter int CW  = 15
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_wrap    = i_en && w_at_last;
  assign o_cnt     = r_cnt;

  // Slot counter: wraps at DIV-1, frozen while disabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_at_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
// Scan controller for a 3-digit multiplexed 7-segment display.
// Rotates a one-hot digit select once per slot, snapshots the BCD value once
// per frame so all three digits of a frame come from one coherent value, and
// drives active-low anodes with a per-slot ghost guard and optional
// leading-zero suppression.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   en           in   scan enable; 0 freezes scanning and darkens the display
//   cdu[11:0]    in   live BCD value ([3:0] units, [7:4] tens, [11:8] hundreds)
//   cdu_o[11:0]  out  frame snapshot of cdu for the digit mux
//   sel[2:0]     out  one-hot digit select (001 units, 010 tens, 100 hundreds)
//   an[2:0]      out  active-low anodes ([0] units, [1] tens, [2] hundreds)
//   tick         out  pulse on the first cycle of each new slot
//   frame_start  out  pulse when sel enters 001 by rotation
// All outputs are functions of registers only.
// ---------------------------------------------------------------------------
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV   = 27000,
  parameter int GUARD         = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  bcd3_t      cdu,
  output bcd3_t      cdu_o,
  output digit_sel_t sel,
  output logic [2:0] an,
  output logic       tick,
  output logic       frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] w_cnt;
  logic          w_wrap;
  digit_sel_t    w_next_sel;
  logic          w_enter_units;
  logic          w_in_guard;
  logic          w_blank_c;
  logic          w_blank_d;
  logic          w_digit_blank;
  logic [2:0]    w_an;

  digit_sel_t    r_sel;
  bcd3_t         r_cdu_o;
  logic          r_tick;
  logic          r_frame_start;
  logic          r_en_q;
  logic          r_load_pending;

  tick_gen #(
    .DIV (REFRESH_DIV),
    .CW  (CW)
  ) u_tick_gen (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .o_cnt  (w_cnt),
    .o_wrap (w_wrap)
  );

  assign w_next_sel    = next_sel(r_sel);
  assign w_enter_units = w_wrap && (w_next_sel == DIG_U);

  // Rotation, pulses, enable pipeline and frame snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel          <= DIG_U;
      r_cdu_o        <= 12'h000;
      r_tick         <= 1'b0;
      r_frame_start  <= 1'b0;
      r_en_q         <= 1'b0;
      r_load_pending <= 1'b1;
    end else begin
      r_en_q <= en;

      if (w_wrap) begin
        r_sel         <= w_next_sel;
        r_tick        <= 1'b1;
        r_frame_start <= w_enter_units;
      end else begin
        r_sel         <= r_sel;
        r_tick        <= 1'b0;
        r_frame_start <= 1'b0;
      end

      // The very first enabled cycle after reset fills the snapshot so the
      // opening frame does not show the reset value.
      if (en && (r_load_pending || w_enter_units)) begin
        r_cdu_o        <= cdu;
        r_load_pending <= 1'b0;
      end else begin
        r_cdu_o        <= r_cdu_o;
        r_load_pending <= r_load_pending;
      end
    end
  end

  // Ghost guard window at the start of each slot (none when GUARD==0).
  generate
    if (GUARD > 0) begin : g_guard
      localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
      assign w_in_guard = (w_cnt < GUARD_C);
    end else begin : g_no_guard
      assign w_in_guard = 1'b0;
    end
  endgenerate

  assign w_blank_c = (BLANK_LEADING != 0) && (r_cdu_o[11:8] == 4'd0);
  assign w_blank_d = w_blank_c && (r_cdu_o[7:4] == 4'd0);

  // Anode drive: dark when disabled, guarding, or the shown digit is a leading zero.
  always_comb begin
    w_digit_blank = 1'b0;
    case (r_sel)
      DIG_C:   w_digit_blank = w_blank_c;
      DIG_D:   w_digit_blank = w_blank_d;
      default: w_digit_blank = 1'b0;
    endcase

    if (!r_en_q || w_in_guard || w_digit_blank) begin
      w_an = 3'b111;
    end else begin
      w_an = ~r_sel;
    end
  end

  assign cdu_o       = r_cdu_o;
  assign sel         = r_sel;
  assign an          = w_an;
  assign tick        = r_tick;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
// Two instances (leading-zero blanking on / off) share one stimulus stream.
// A reference model tracks the number of enabled cycles since reset and
// derives slot position, digit, pulses and anodes arithmetically from it.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int DIV   = 4;
  localparam int GUARD = 1;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] cdu;

  logic [11:0] cdu_o_a, cdu_o_b;
  logic [2:0]  sel_a, sel_b, an_a, an_b;
  logic        tick_a, tick_b, fs_a, fs_b;

  int n_chk = 0;
  int n_err = 0;

  display_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD(GUARD), .BLANK_LEADING(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .cdu(cdu),
    .cdu_o(cdu_o_a), .sel(sel_a), .an(an_a), .tick(tick_a), .frame_start(fs_a)
  );

  display_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD(GUARD), .BLANK_LEADING(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .cdu(cdu),
    .cdu_o(cdu_o_b), .sel(sel_b), .an(an_b), .tick(tick_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_n      = 0;   // enabled cycles since reset
  bit          m_en_q   = 1'b0;
  bit          m_pend   = 1'b1;
  bit          m_tick   = 1'b0;
  bit          m_fs     = 1'b0;
  bit          m_valid  = 1'b0;
  logic [11:0] m_snap   = 12'h000;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_n = 0; m_en_q = 1'b0; m_pend = 1'b1; m_tick = 1'b0; m_fs = 1'b0;
        m_snap = 12'h000; m_valid = 1'b1;
      end else begin
        m_en_q = en;
        if (en) begin
          m_n    = m_n + 1;
          m_tick = (m_n % DIV) == 0;
          m_fs   = m_tick && (((m_n / DIV) % 3) == 0);
          if (m_pend || m_fs) m_snap = cdu;
          m_pend = 1'b0;
        end else begin
          m_tick = 1'b0;
          m_fs   = 1'b0;
        end
      end
    end
  end

  function automatic int m_digit();
    return (m_n / DIV) % 3;
  endfunction

  function automatic logic [2:0] m_sel();
    logic [2:0] one;
    one = 3'b001;
    return one << m_digit();
  endfunction

  function automatic logic [2:0] m_an(input bit blank_on);
    int d;
    d = m_digit();
    if (!m_en_q || ((m_n % DIV) < GUARD)) return 3'b111;
    if (blank_on && d == 2 && m_snap[11:8] == 4'd0) return 3'b111;
    if (blank_on && d == 1 && m_snap[11:4] == 8'd0) return 3'b111;
    return ~m_sel();
  endfunction

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("a.sel",   32'(sel_a),   32'(m_sel()));
        chk("a.an",    32'(an_a),    32'(m_an(1'b1)));
        chk("a.cdu_o", 32'(cdu_o_a), 32'(m_snap));
        chk("a.tick",  32'(tick_a),  32'(m_tick));
        chk("a.fs",    32'(fs_a),    32'(m_fs));
        chk("b.sel",   32'(sel_b),   32'(m_sel()));
        chk("b.an",    32'(an_b),    32'(m_an(1'b0)));
        chk("b.cdu_o", 32'(cdu_o_b), 32'(m_snap));
        chk("b.tick",  32'(tick_b),  32'(m_tick));
        chk("b.fs",    32'(fs_b),    32'(m_fs));
      end
    end
  end

  // ---------------- stimulus + literal expectations ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [2:0] exp_an_tbl [0:12];

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v;
    for (int i = 0; i < 3; i++) begin
      v[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  initial begin
    exp_an_tbl = '{3'b111, 3'b110, 3'b110, 3'b110,
                   3'b111, 3'b101, 3'b101, 3'b101,
                   3'b111, 3'b011, 3'b011, 3'b011,
                   3'b111};
    rst = 1'b1; en = 1'b0; cdu = 12'h000;
    step(3);

    // Reset state.
    chk("rst.sel",   32'(sel_a),   32'h1);
    chk("rst.an",    32'(an_a),    32'h7);
    chk("rst.cdu_o", 32'(cdu_o_a), 32'h0);
    chk("rst.tick",  32'(tick_a),  32'h0);
    chk("rst.fs",    32'(fs_a),    32'h0);

    // Release with en=1, cdu=123: cycle 0 is the current (reset) state.
    rst = 1'b0; en = 1'b1; cdu = 12'h123;
    chk("scan.an0", 32'(an_a), 32'(exp_an_tbl[0]));
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("scan.an", 32'(an_a), 32'(exp_an_tbl[k]));
      chk("scan.tick", 32'(tick_a), 32'((k % 4) == 0));
      if (k == 6) cdu = 12'h456;            // mid tens slot
      if (k == 11) chk("coh.hold", 32'(cdu_o_a), 32'h123);
    end
    chk("coh.new", 32'(cdu_o_a), 32'h456);
    chk("coh.fs",  32'(fs_a),    32'h1);
    chk("coh.sel", 32'(sel_a),   32'h1);

    // Freeze at tens slot cnt=2 (cycle 18).
    step(6);
    chk("frz.sel0", 32'(sel_a), 32'h2);
    en = 1'b0;
    step(1);
    chk("frz.an",  32'(an_a),  32'h7);
    chk("frz.sel", 32'(sel_a), 32'h2);
    step(9);
    chk("frz.sel9", 32'(sel_a), 32'h2);
    en = 1'b1;
    step(1);
    chk("res.an",  32'(an_a),  32'h5);
    chk("res.sel", 32'(sel_a), 32'h2);
    step(1);
    chk("res.sel2", 32'(sel_a),  32'h4);
    chk("res.tick", 32'(tick_a), 32'h1);

    // Reset during the hundreds slot.
    step(1);
    rst = 1'b1;
    step(1);
    chk("mrst.sel",   32'(sel_a),   32'h1);
    chk("mrst.an",    32'(an_a),    32'h7);
    chk("mrst.cdu_o", 32'(cdu_o_a), 32'h0);
    rst = 1'b0; cdu = 12'h007;
    step(1);
    chk("mrst.load", 32'(cdu_o_a), 32'h007);
    chk("blk.u_a",   32'(an_a),    32'h6);
    chk("blk.u_b",   32'(an_b),    32'h6);
    step(4);
    chk("blk.d_a",   32'(an_a),    32'h7);
    chk("blk.d_b",   32'(an_b),    32'h5);
    step(4);
    chk("blk.c_a",   32'(an_a),    32'h7);
    chk("blk.c_b",   32'(an_b),    32'h3);

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) cdu = rand_bcd();
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
